// File: rtl/mhp_frame_engine.sv
// rtl/mhp_frame_engine.sv - receive a payload frame, end it on an idle gap, emit a padded reply
// Reply is echo, zero-fill or header+payload, optionally started on the next time tick.
module mhp_frame_engine #(
  parameter int           ADDR_W   = 8,
  parameter int           GAP_CYC  = 62,
  parameter int           MIN_LEN  = 50,
  parameter int           HDR_LEN  = 9,
  parameter logic [127:0] HDR      = 128'hffff0000_00008305_09000000_00000000,
  parameter int           TICK_DIV = 50000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [1:0]      i_mode,
  input  logic            i_tick_sync,
  input  logic [7:0]      i_rdata,
  input  logic            i_rready,
  output logic            o_rreq,
  output logic [7:0]      o_wdata,
  input  logic            i_wready,
  output logic            o_wvalid,
  output logic            o_done,
  output logic            o_ovf,
  output logic [ADDR_W:0] o_rx_len,
  output logic [15:0]     o_frames,
  output logic [31:0]     o_time
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LEN_W = ADDR_W + 1;
  localparam int OUT_W = ADDR_W + 2;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
  localparam logic [OUT_W-1:0] HDR_LEN_L = OUT_W'(HDR_LEN);
  localparam logic [OUT_W-1:0] MIN_LEN_L = OUT_W'(MIN_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [31:0]      DIV_LAST  = 32'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_GAP,
    S_END,
    S_WAIT_TICK,
    S_TX_ISSUE,
    S_TX_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rx_len_q;
  logic [GAP_W-1:0] gap_q;
  logic [OUT_W-1:0] idx_q;
  logic [OUT_W-1:0] out_len_q;
  logic [1:0]       mode_q;
  logic             rreq_q;
  logic             wvalid_q;
  logic             done_q;
  logic             ovf_q;
  logic             tick_q;
  logic [7:0]       wdata_q;
  logic [15:0]      frames_q;
  logic [31:0]      time_q;
  logic [31:0]      div_q;

  logic [1:0]       mode_d;
  logic [OUT_W-1:0] body_len_d;
  logic [OUT_W-1:0] out_len_d;
  logic [OUT_W-1:0] idx_inc_d;
  logic [OUT_W-1:0] pay_idx_d;
  logic [6:0]       hdr_sel_d;
  logic [7:0]       tx_byte_d;

  // Mode 3 is folded onto echo once, so the byte mux only knows three modes.
  always_comb begin
    mode_d     = (i_mode == 2'd3) ? 2'd0 : i_mode;
    body_len_d = {1'b0, len_q} + ((mode_d == 2'd2) ? HDR_LEN_L : '0);
    out_len_d  = (body_len_d < MIN_LEN_L) ? MIN_LEN_L : body_len_d;
  end

  always_comb begin
    idx_inc_d = idx_q + 1'b1;
    hdr_sel_d = {4'd15 - idx_q[3:0], 3'b000};
    pay_idx_d = (mode_q == 2'd2) ? idx_q - HDR_LEN_L : idx_q;
    tx_byte_d = 8'h00;
    if (mode_q == 2'd2 && idx_q < HDR_LEN_L) begin
      tx_byte_d = HDR[hdr_sel_d +: 8];
    end else if (mode_q != 2'd1 && pay_idx_d < {1'b0, rx_len_q}) begin
      tx_byte_d = mem_q[pay_idx_d[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q  <= '0;
      time_q <= '0;
      tick_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      time_q <= time_q + 1'b1;
      tick_q <= 1'b1;
    end else begin
      div_q  <= div_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == S_RD_CAP && len_q < DEPTH_L) begin
      mem_q[len_q[ADDR_W-1:0]] <= i_rdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rx_len_q  <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      out_len_q <= '0;
      mode_q    <= 2'd0;
      rreq_q    <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wdata_q   <= 8'h00;
      frames_q  <= '0;
    end else begin
      rreq_q   <= 1'b0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_rready) begin
            len_q   <= '0;
            ovf_q   <= 1'b0;
            rreq_q  <= 1'b1;
            state_q <= S_RD_REQ;
          end
        end
        S_RD_REQ: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          if (len_q < DEPTH_L) begin
            len_q <= len_q + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
          gap_q   <= '0;
          state_q <= S_RD_GAP;
        end
        S_RD_GAP: begin
          if (i_rready) begin
            rreq_q  <= 1'b1;
            state_q <= S_RD_REQ;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_END;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_END: begin
          rx_len_q  <= len_q;
          frames_q  <= frames_q + 1'b1;
          mode_q    <= mode_d;
          out_len_q <= out_len_d;
          idx_q     <= '0;
          if (!i_en) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (i_tick_sync) begin
            state_q <= S_WAIT_TICK;
          end else begin
            state_q <= S_TX_ISSUE;
          end
        end
        // tick_q is a one-cycle pulse, so a tick seen while in END is already gone here.
        S_WAIT_TICK: begin
          if (tick_q) begin
            state_q <= S_TX_ISSUE;
          end
        end
        S_TX_ISSUE: begin
          if (i_wready) begin
            wdata_q  <= tx_byte_d;
            wvalid_q <= 1'b1;
            state_q  <= S_TX_GAP;
          end
        end
        S_TX_GAP: begin
          idx_q <= idx_inc_d;
          if (idx_inc_d == out_len_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_TX_ISSUE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rreq   = rreq_q;
  assign o_wdata  = wdata_q;
  assign o_wvalid = wvalid_q;
  assign o_done   = done_q;
  assign o_ovf    = ovf_q;
  assign o_rx_len = rx_len_q;
  assign o_frames = frames_q;
  assign o_time   = time_q;

endmodule

// File: tb/tb_mhp_frame_engine.sv
// tb/tb_mhp_frame_engine.sv - randomized self-checking bench for mhp_frame_engine
// Frame-level reference model builds each expected reply as a byte queue.
module tb_mhp_frame_engine;
  localparam int ADDR_W   = 8;
  localparam int GAP_CYC  = 62;
  localparam int MIN_LEN  = 50;
  localparam int HDR_LEN  = 9;
  localparam int TICK_DIV = 100;
  localparam int DEPTH    = 256;

  typedef byte unsigned bq_t[$];

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic [1:0]  i_mode = 2'd0;
  logic        i_tick_sync = 1'b0;
  logic [7:0]  i_rdata = 8'h00;
  logic        i_rready = 1'b0;
  logic        i_wready = 1'b1;
  logic        o_rreq;
  logic [7:0]  o_wdata;
  logic        o_wvalid;
  logic        o_done;
  logic        o_ovf;
  logic [8:0]  o_rx_len;
  logic [15:0] o_frames;
  logic [31:0] o_time;

  always #5 i_clk = ~i_clk;

  mhp_frame_engine #(
    .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC), .MIN_LEN(MIN_LEN), .HDR_LEN(HDR_LEN),
    .HDR(128'hffff0000_00008305_09000000_00000000), .TICK_DIV(TICK_DIV)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_tick_sync(i_tick_sync),
    .i_rdata(i_rdata), .i_rready(i_rready), .o_rreq(o_rreq), .o_wdata(o_wdata),
    .i_wready(i_wready), .o_wvalid(o_wvalid), .o_done(o_done), .o_ovf(o_ovf),
    .o_rx_len(o_rx_len), .o_frames(o_frames), .o_time(o_time)
  );

  int   vectors = 0;
  int   miscompares = 0;
  bq_t  rxq;
  bq_t  exp_q;
  int   cyc = 0;
  int   pops = 0;
  int   dones = 0;
  int   frames_exp = 0;
  int   last_time_cyc = -1;
  logic [31:0] prev_time = 32'd0;
  logic wr_edge = 1'b0;
  logic wvalid_prev = 1'b0;
  logic rreq_prev = 1'b0;
  logic sync_first = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic byte unsigned hdr_byte(input int i);
    case (i)
      0, 1:    return 8'hff;
      6:       return 8'h83;
      7:       return 8'h05;
      8:       return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bq_t build_reply(input bq_t fr, input int mode);
    bq_t r;
    int stored;
    stored = (fr.size() > DEPTH) ? DEPTH : fr.size();
    r = {};
    if (mode == 2) for (int i = 0; i < HDR_LEN; i++) r.push_back(hdr_byte(i));
    for (int i = 0; i < stored; i++) r.push_back((mode == 1) ? 8'h00 : fr[i]);
    while (r.size() < MIN_LEN) r.push_back(8'h00);
    return r;
  endfunction

  always @(posedge i_clk) wr_edge <= i_wready;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      last_time_cyc = -1;
      prev_time = o_time;
      wvalid_prev = 1'b0;
      rreq_prev = 1'b0;
    end else begin
      if (o_time != prev_time) begin
        if (last_time_cyc >= 0) begin
          check("tick_period", cyc - last_time_cyc, TICK_DIV);
          check("time_step", o_time, prev_time + 32'd1);
        end
        last_time_cyc = cyc;
        prev_time = o_time;
      end
      if (o_wvalid) begin
        check("wready_before_wvalid", wr_edge, 1);
        check("wvalid_single", wvalid_prev, 0);
        check("reply_byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("reply_byte", o_wdata, exp_q.pop_front());
        if (sync_first) begin
          check("tick_sync_start", cyc - last_time_cyc, 2);
          sync_first = 1'b0;
        end
      end
      wvalid_prev = o_wvalid;
      if (o_rreq) begin
        check("rreq_when_ready", i_rready, 1);
        check("rreq_single", rreq_prev, 0);
        pops++;
        if (rxq.size() > 0) i_rdata = rxq.pop_front();
        i_rready = (rxq.size() != 0);
      end
      rreq_prev = o_rreq;
      if (o_done) dones++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic push(input byte unsigned b);
    rxq.push_back(b);
    i_rready = 1'b1;
  endtask

  task automatic run_frame(input bq_t fr, input int mode, input bit en, input bit ts,
                           input int space, input bit rnd_wr, input int stall_at, input string tag);
    bq_t r;
    int p0, d0, t;
    bit stalled;
    stalled = 1'b0;
    i_en = en;
    i_mode = 2'(mode);
    i_tick_sync = ts;
    if (en) begin
      r = build_reply(fr, mode);
      foreach (r[i]) exp_q.push_back(r[i]);
    end
    sync_first = ts & en;
    p0 = pops;
    d0 = dones;
    foreach (fr[i]) begin
      if (space > 0) step($urandom_range(space, 0));
      push(fr[i]);
    end
    t = 0;
    while (dones == d0 && t < 4000) begin
      if (stall_at > 0 && !stalled && exp_q.size() == stall_at) begin
        i_wready = 1'b0;
        step(20);
        t += 20;
        i_wready = 1'b1;
        stalled = 1'b1;
      end
      step(1);
      t++;
      if (rnd_wr) i_wready = ($urandom_range(3, 0) != 0);
    end
    i_wready = 1'b1;
    frames_exp++;
    check({tag, "_timeout"}, t < 4000, 1);
    check({tag, "_pops"}, pops - p0, fr.size());
    check({tag, "_rx_len"}, o_rx_len, (fr.size() > DEPTH) ? DEPTH : fr.size());
    check({tag, "_ovf"}, o_ovf, fr.size() > DEPTH);
    check({tag, "_reply_left"}, exp_q.size(), 0);
    check({tag, "_frames"}, o_frames, frames_exp);
    step(3);
    check({tag, "_done_pulses"}, dones - d0, 1);
  endtask

  task automatic gap_test(input int n, input string tag);
    bq_t a, b, r;
    byte unsigned b1, b2;
    int d0, nf, t;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    i_en = 1'b1;
    i_mode = 2'd0;
    i_tick_sync = 1'b0;
    if (n >= GAP_CYC) begin
      nf = 2;
      a = {b1};
      b = {b2};
      r = build_reply(a, 0);
      foreach (r[i]) exp_q.push_back(r[i]);
      r = build_reply(b, 0);
      foreach (r[i]) exp_q.push_back(r[i]);
    end else begin
      nf = 1;
      a = {b1, b2};
      r = build_reply(a, 0);
      foreach (r[i]) exp_q.push_back(r[i]);
    end
    d0 = dones;
    push(b1);
    t = 0;
    do begin
      step(1);
      t++;
    end while (!o_rreq && t < 100);
    check({tag, "_rreq_seen"}, o_rreq, 1);
    step(n + 2);
    push(b2);
    t = 0;
    while (dones - d0 < nf && t < 4000) begin
      step(1);
      t++;
    end
    frames_exp += nf;
    check({tag, "_timeout"}, t < 4000, 1);
    check({tag, "_frames"}, o_frames, frames_exp);
    check({tag, "_rx_len"}, o_rx_len, (nf == 2) ? 1 : 2);
    check({tag, "_reply_left"}, exp_q.size(), 0);
    step(3);
    check({tag, "_done_pulses"}, dones - d0, nf);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr, r;
    int d0, t;
    step(3);
    check("rst_rreq", o_rreq, 0);
    check("rst_wvalid", o_wvalid, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_done", o_done, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_rx_len", o_rx_len, 0);
    check("rst_frames", o_frames, 0);
    check("rst_time", o_time, 0);
    i_rst = 1'b0;

    fr = {8'hAA, 8'hBB, 8'hCC};
    r = build_reply(fr, 0);
    check("model_t1_len", r.size(), 50);
    check("model_t1_b2", r[2], 8'hCC);
    check("model_t1_b3", r[3], 8'h00);
    run_frame(fr, 0, 1, 0, 0, 0, 0, "t1");
    check("t1_rx_len_lit", o_rx_len, 3);
    check("t1_frames_lit", o_frames, 1);

    fr = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    r = build_reply(fr, 2);
    check("model_t2_len", r.size(), 50);
    check("model_t2_b6", r[6], 8'h83);
    check("model_t2_b8", r[8], 8'h09);
    check("model_t2_b9", r[9], 8'h01);
    check("model_t2_b13", r[13], 8'h05);
    check("model_t2_b14", r[14], 8'h00);
    run_frame(fr, 2, 1, 0, 4, 0, 0, "t2");

    fr = {};
    for (int i = 0; i < 300; i++) fr.push_back(8'($urandom));
    r = build_reply(fr, 0);
    check("model_t3_len", r.size(), 256);
    run_frame(fr, 0, 1, 0, 0, 0, 0, "t3");
    check("t3_ovf_lit", o_ovf, 1);
    check("t3_rx_len_lit", o_rx_len, 256);

    for (int k = 0; k < 8; k++) begin
      fr = {};
      for (int i = 0; i < int'($urandom_range(80, 1)); i++) fr.push_back(8'($urandom));
      run_frame(fr, int'($urandom_range(3, 0)), ($urandom_range(4, 0) != 0), 0, 10, 1, 0, "rnd");
    end

    fr = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'($urandom));
    run_frame(fr, 2, 1, 1, 3, 0, 30, "t4");

    fr = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(fr, 0, 0, 0, 2, 0, 0, "t5_discard");

    gap_test(GAP_CYC - 1, "t6_short_gap");
    gap_test(GAP_CYC, "t6_long_gap");

    fr = {};
    for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
    i_en = 1'b1;
    i_mode = 2'd0;
    i_tick_sync = 1'b0;
    r = build_reply(fr, 0);
    foreach (r[i]) exp_q.push_back(r[i]);
    foreach (fr[i]) push(fr[i]);
    t = 0;
    while (exp_q.size() >= 40 && t < 2000) begin
      step(1);
      t++;
    end
    check("t5_reach_tx", exp_q.size() < 40, 1);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("t5_rst_rreq", o_rreq, 0);
    check("t5_rst_wvalid", o_wvalid, 0);
    check("t5_rst_wdata", o_wdata, 0);
    check("t5_rst_done", o_done, 0);
    check("t5_rst_ovf", o_ovf, 0);
    check("t5_rst_rx_len", o_rx_len, 0);
    check("t5_rst_frames", o_frames, 0);
    check("t5_rst_time", o_time, 0);
    exp_q.delete();
    rxq.delete();
    i_rready = 1'b0;
    frames_exp = 0;
    sync_first = 1'b0;
    step(3);
    i_rst = 1'b0;
    d0 = dones;
    step(150);
    check("t5_post_rst_done", dones - d0, 0);
    check("t5_post_rst_frames", o_frames, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
